// File: rtl/writeback_pkg.sv
// Shared types and widths for the writeback stage.
// Register index width and word width come from `W_RD / `WORD; defaults apply when not predefined.
`ifndef W_RD
`define W_RD 5
`endif
`ifndef WORD
`define WORD 32
`endif

package writeback_pkg;
   localparam int W_RD   = `W_RD;
   localparam int WORD_W = `WORD;
   localparam int NREG   = 1 << W_RD;

   typedef logic [W_RD-1:0]   reg_idx_t;
   typedef logic [WORD_W-1:0] word_t;

   typedef struct packed {
      logic     we;
      reg_idx_t num;
      word_t    data;
   } wr_req_t;
endpackage

// File: rtl/writeback_if.sv
// EX -> writeback result bus, with the stall returned to EX.
interface wb_if;
   import writeback_pkg::*;

   logic     v_i;
   logic     stall_o;
   logic     wb_i;
   reg_idx_t rd_num_i;
   word_t    rd_data_i;

   modport master (output v_i, wb_i, rd_num_i, rd_data_i, input stall_o);
   modport slave  (input v_i, wb_i, rd_num_i, rd_data_i, output stall_o);
endinterface

// File: rtl/writeback_regfile.sv
// Architectural register file: one write port, two asynchronous read ports, r0 reads zero.
// Define WB_BYPASS_EN to forward the write in flight to a read port with a matching index.
module wb_regfile
   import writeback_pkg::*;
(
   input  logic     clk,
   input  logic     rst,
   input  wr_req_t  i_wr,
   input  reg_idx_t i_rd_num [2],
   output word_t    o_rd_data [2]
);
   word_t r_regs [NREG];

   // Entry 0 is never written, so it stays at its reset value of zero.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
      end else if (i_wr.we && i_wr.num != '0) begin
         r_regs[i_wr.num] <= i_wr.data;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_rd
         word_t w_stored;
         assign w_stored = (i_rd_num[gi] == '0) ? '0 : r_regs[i_rd_num[gi]];
`ifdef WB_BYPASS_EN
         assign o_rd_data[gi] = (i_wr.we && i_wr.num != '0 && i_wr.num == i_rd_num[gi])
                                ? i_wr.data : w_stored;
`else
         assign o_rd_data[gi] = w_stored;
`endif
      end
   endgenerate
endmodule

// File: rtl/writeback.sv
// Writeback stage: arbitrates the single register write port (debug wins) and counts retirements.
// Optional WB_BYPASS_EN forwards same-cycle writes to the decode read ports.
module writeback
   import writeback_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   wb_if.slave              ex,
   input  reg_idx_t         rs_num_i,
   input  reg_idx_t         rt_num_i,
   output word_t            rs_data_o,
   output word_t            rt_data_o,
   input  logic             dbg_we_i,
   input  reg_idx_t         dbg_num_i,
   input  word_t            dbg_data_i,
   output logic [CNT_W-1:0] retired_o
);
   logic             w_stall;
   logic             w_commit;
   wr_req_t          w_wr;
   reg_idx_t         w_rd_num [2];
   word_t            w_rd_data [2];
   logic [CNT_W-1:0] r_retired;

   // Only an instruction that needs the write port can collide with a debug write.
   assign w_stall    = ex.v_i & ex.wb_i & dbg_we_i;
   assign w_commit   = ex.v_i & ~w_stall & rst;
   assign ex.stall_o = w_stall;

   always_comb begin
      w_wr = '0;
      if (dbg_we_i) begin
         w_wr.we   = rst;
         w_wr.num  = dbg_num_i;
         w_wr.data = dbg_data_i;
      end else if (w_commit && ex.wb_i) begin
         w_wr.we   = 1'b1;
         w_wr.num  = ex.rd_num_i;
         w_wr.data = ex.rd_data_i;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_retired <= '0;
      end else if (w_commit) begin
         r_retired <= r_retired + CNT_W'(1);
      end
   end

   assign retired_o   = r_retired;
   assign w_rd_num[0] = rs_num_i;
   assign w_rd_num[1] = rt_num_i;
   assign rs_data_o   = w_rd_data[0];
   assign rt_data_o   = w_rd_data[1];

   wb_regfile u_regfile (
      .clk       (clk),
      .rst       (rst),
      .i_wr      (w_wr),
      .i_rd_num  (w_rd_num),
      .o_rd_data (w_rd_data)
   );
endmodule

// File: tb/tb_writeback.sv
// Directed bench for writeback: reset, commit table, debug-collision stall, bypass, counter wrap.
`timescale 1ns/1ps
module tb_writeback;
   import writeback_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   reg_idx_t   rs_num, rt_num, dbg_num;
   word_t      rs_data, rt_data, dbg_data;
   logic       dbg_we;
   logic [3:0] retired;
   int         checks = 0;
   int         errors = 0;

   always #5 clk = ~clk;

   wb_if ex();

   writeback #(.CNT_W(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .ex         (ex),
      .rs_num_i   (rs_num),
      .rt_num_i   (rt_num),
      .rs_data_o  (rs_data),
      .rt_data_o  (rt_data),
      .dbg_we_i   (dbg_we),
      .dbg_num_i  (dbg_num),
      .dbg_data_i (dbg_data),
      .retired_o  (retired)
   );

   typedef struct {
      logic       v;
      logic       wb;
      reg_idx_t   rd;
      word_t      d;
      logic       dwe;
      reg_idx_t   dn;
      word_t      dd;
      reg_idx_t   rs;
      reg_idx_t   rt;
      logic       stall;
      word_t      ers;
      word_t      ert;
      logic [3:0] eret;
   } vec_t;

   vec_t vecs [9];

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end else begin
         $display("ok   %s: 0x%0h", name, act);
      end
   endtask

   task automatic drive(logic v, logic wb, reg_idx_t rd, word_t d,
                        logic dwe, reg_idx_t dn, word_t dd, reg_idx_t rs, reg_idx_t rt);
      ex.v_i       = v;
      ex.wb_i      = wb;
      ex.rd_num_i  = rd;
      ex.rd_data_i = d;
      dbg_we       = dwe;
      dbg_num      = dn;
      dbg_data     = dd;
      rs_num       = rs;
      rt_num       = rt;
   endtask

   task automatic idle();
      ex.v_i = 1'b0;
      ex.wb_i = 1'b0;
      dbg_we = 1'b0;
   endtask

   initial begin
      vecs[0] = '{1'b1, 1'b1, 5'd3,  32'hDEAD, 1'b0, 5'd0, 32'h0,    5'd3,  5'd0,  1'b0, 32'hDEAD, 32'h0,    4'd1};
      vecs[1] = '{1'b1, 1'b1, 5'd0,  32'hFFFF, 1'b0, 5'd0, 32'h0,    5'd0,  5'd3,  1'b0, 32'h0,    32'hDEAD, 4'd2};
      vecs[2] = '{1'b1, 1'b0, 5'd6,  32'h1111, 1'b1, 5'd6, 32'h2222, 5'd6,  5'd3,  1'b0, 32'h2222, 32'hDEAD, 4'd3};
      vecs[3] = '{1'b0, 1'b1, 5'd7,  32'h7777, 1'b0, 5'd0, 32'h0,    5'd7,  5'd7,  1'b0, 32'h0,    32'h0,    4'd3};
      vecs[4] = '{1'b0, 1'b0, 5'd0,  32'h0,    1'b1, 5'd9, 32'h9999, 5'd9,  5'd6,  1'b0, 32'h9999, 32'h2222, 4'd3};
      vecs[5] = '{1'b1, 1'b1, 5'd31, 32'h3131, 1'b0, 5'd0, 32'h0,    5'd31, 5'd9,  1'b0, 32'h3131, 32'h9999, 4'd4};
      vecs[6] = '{1'b1, 1'b1, 5'd3,  32'h0033, 1'b0, 5'd0, 32'h0,    5'd3,  5'd31, 1'b0, 32'h0033, 32'h3131, 4'd5};
      vecs[7] = '{1'b0, 1'b0, 5'd0,  32'h0,    1'b1, 5'd0, 32'hFFFF, 5'd0,  5'd3,  1'b0, 32'h0,    32'h0033, 4'd5};
      vecs[8] = '{1'b1, 1'b0, 5'd12, 32'h1212, 1'b0, 5'd0, 32'h0,    5'd12, 5'd0,  1'b0, 32'h0,    32'h0,    4'd6};

      // Power-on reset.
      drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd0);
      #12;
      chk("por_retired", {28'h0, retired}, 32'h0);
      chk("por_rs", rs_data, 32'h0);
      chk("por_stall", {31'h0, ex.stall_o}, 32'h0);
      @(negedge clk) rst = 1'b1;

      // Commit r5, then reset asynchronously in the middle of another commit.
      @(posedge clk); #1;
      drive(1'b1, 1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'h0, 5'd5, 5'd8);
      @(posedge clk); #1;
      idle(); #1;
      chk("pre_rst_r5", rs_data, 32'h1234);
      chk("pre_rst_retired", {28'h0, retired}, 32'h1);
      drive(1'b1, 1'b1, 5'd8, 32'h5555, 1'b0, 5'd0, 32'h0, 5'd5, 5'd8);
      @(negedge clk) rst = 1'b0;
      #1;
      chk("async_rst_r5", rs_data, 32'h0);
      chk("async_rst_retired", {28'h0, retired}, 32'h0);
      @(posedge clk); #1;
      chk("in_rst_r8", rt_data, 32'h0);
      chk("in_rst_retired", {28'h0, retired}, 32'h0);
      idle();
      @(negedge clk) rst = 1'b1;
      #1;
      chk("post_rst_r8", rt_data, 32'h0);

      // Table of single-cycle transactions.
      for (int i = 0; i < 9; i++) begin
         @(posedge clk); #1;
         drive(vecs[i].v, vecs[i].wb, vecs[i].rd, vecs[i].d, vecs[i].dwe,
               vecs[i].dn, vecs[i].dd, vecs[i].rs, vecs[i].rt);
         @(negedge clk);
         chk($sformatf("v%0d_stall", i), {31'h0, ex.stall_o}, {31'h0, vecs[i].stall});
         @(posedge clk); #1;
         idle(); #1;
         chk($sformatf("v%0d_rs", i), rs_data, vecs[i].ers);
         chk($sformatf("v%0d_rt", i), rt_data, vecs[i].ert);
         chk($sformatf("v%0d_retired", i), {28'h0, retired}, {28'h0, vecs[i].eret});
      end

      // Debug write collides with an EX write: EX holds, then commits once.
      @(posedge clk); #1;
      drive(1'b1, 1'b1, 5'd4, 32'hAAAA, 1'b1, 5'd4, 32'h5555, 5'd0, 5'd0);
      @(negedge clk);
      chk("coll_stall", {31'h0, ex.stall_o}, 32'h1);
      @(posedge clk); #1;
      dbg_we = 1'b0;
      rs_num = 5'd4;
      @(negedge clk);
      chk("coll_release_stall", {31'h0, ex.stall_o}, 32'h0);
`ifdef WB_BYPASS_EN
      chk("coll_r4_dbg", rs_data, 32'hAAAA);
`else
      chk("coll_r4_dbg", rs_data, 32'h5555);
`endif
      chk("coll_retired_held", {28'h0, retired}, 32'h6);
      @(posedge clk); #1;
      idle(); #1;
      chk("coll_r4_ex", rs_data, 32'hAAAA);
      chk("coll_retired_once", {28'h0, retired}, 32'h7);

      // Same-cycle read of the register being written.
      @(posedge clk); #1;
      drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h7070, 5'd7, 5'd7);
      @(posedge clk); #1;
      drive(1'b1, 1'b1, 5'd7, 32'h0BEE, 1'b0, 5'd0, 32'h0, 5'd7, 5'd7);
      #1;
`ifdef WB_BYPASS_EN
      chk("byp_ex_rs", rs_data, 32'h0BEE);
      chk("byp_ex_rt", rt_data, 32'h0BEE);
`else
      chk("byp_ex_rs", rs_data, 32'h7070);
      chk("byp_ex_rt", rt_data, 32'h7070);
`endif
      @(posedge clk); #1;
      drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h0D0D, 5'd7, 5'd6);
      #1;
`ifdef WB_BYPASS_EN
      chk("byp_dbg_rs", rs_data, 32'h0D0D);
`else
      chk("byp_dbg_rs", rs_data, 32'h0BEE);
`endif
      chk("byp_dbg_rt_other", rt_data, 32'h2222);
      chk("byp_retired", {28'h0, retired}, 32'h8);
      @(posedge clk); #1;
      idle(); #1;
      chk("byp_r7_final", rs_data, 32'h0D0D);

      // Counter wrap: run up to all-ones, then one more commit.
      for (int k = 0; k < 7; k++) begin
         @(posedge clk); #1;
         drive(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd2, 5'd0);
      end
      @(posedge clk); #1;
      idle(); #1;
      chk("wrap_all_ones", {28'h0, retired}, 32'hF);
      drive(1'b1, 1'b1, 5'd2, 32'h2, 1'b0, 5'd0, 32'h0, 5'd2, 5'd0);
      @(posedge clk); #1;
      idle(); #1;
      chk("wrap_zero", {28'h0, retired}, 32'h0);
      chk("wrap_r2", rs_data, 32'h2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
